// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module : pipe_addsub
// Skewed-pipeline add/subtract: one LIMB-bit ripple segment per register stage,
// with a valid/ready handshake, carry/borrow in/out and signed overflow.
// Revision: 1.0
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH = 64,
    parameter int LIMB  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    // WIDTH is expected to be an exact multiple of LIMB.
    localparam int STAGES = WIDTH / LIMB;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand limbs k..STAGES-1 are still unresolved when entering stage k.
        localparam int OPW = WIDTH - k * LIMB;

        logic                  adv;
        logic                  v_q;
        logic                  sub_q;
        logic                  c_q;
        logic [(k+1)*LIMB-1:0] r_q;
        logic                  v_in;
        logic                  sub_in;
        logic                  c_in;
        logic [OPW-1:0]        a_in;
        logic [OPW-1:0]        b_in;
        logic [LIMB-1:0]       b_eff;
        logic [LIMB:0]         sum_d;
        logic [(k+1)*LIMB-1:0] r_d;

        if (k == 0) begin : g_head
            // Internal carry is the inverted borrow when subtracting.
            assign v_in   = in_valid;
            assign a_in   = a;
            assign b_in   = b;
            assign sub_in = sub;
            assign c_in   = cin ^ sub;
            assign r_d    = sum_d[LIMB-1:0];
        end else begin : g_body
            assign v_in   = g_stage[k-1].v_q;
            assign a_in   = g_stage[k-1].g_mid.a_q;
            assign b_in   = g_stage[k-1].g_mid.b_q;
            assign sub_in = g_stage[k-1].sub_q;
            assign c_in   = g_stage[k-1].c_q;
            assign r_d    = {sum_d[LIMB-1:0], g_stage[k-1].r_q};
        end

        assign b_eff = b_in[LIMB-1:0] ^ {LIMB{sub_in}};
        assign sum_d = {1'b0, a_in[LIMB-1:0]} + {1'b0, b_eff} + {{LIMB{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sub_q <= 1'b0;
                c_q   <= 1'b0;
                r_q   <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    sub_q <= sub_in;
                    c_q   <= sum_d[LIMB];
                    r_q   <= r_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic ovf_d;
            logic ovf_q;

            assign adv   = out_ready | ~v_q;
            // The top limb is resolved here, so all three sign bits are at hand.
            assign ovf_d = ((a_in[LIMB-1] ^ b_in[LIMB-1]) == sub_in) &&
                           (sum_d[LIMB-1] != a_in[LIMB-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            logic [OPW-LIMB-1:0] a_q;
            logic [OPW-LIMB-1:0] b_q;

            assign adv = g_stage[k+1].adv | ~v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_in[OPW-1:LIMB];
                    b_q <= b_in[OPW-1:LIMB];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].adv;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign result    = g_stage[STAGES-1].r_q;
    assign cout      = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].sub_q;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule
`default_nettype wire

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit that generalises the fixed 64-bit two-stage ripple subtractor to any WIDTH split into LIMB-bit ripple segments, with one register stage per limb. It supports runtime add/sub mode, carry/borrow in and out, and signed overflow. A valid/ready handshake with backpressure lets it sit directly in the complex-multiplier datapath, for example forming real = ac − bd and imag = ad + bc on Vedic partial-product outputs.

## Interface
- WIDTH, 64, operand/result width in bits; must be a multiple of LIMB
- LIMB, 32, bits resolved per pipeline stage; STAGES = WIDTH/LIMB (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input operation present
- in_ready  out  1  unit accepts input this cycle
- a  in  WIDTH  minuend / first addend
- b  in  WIDTH  subtrahend / second addend
- sub  in  1  1 = a − b − cin (subtract), 0 = a + b + cin (add)
- cin  in  1  carry-in (add) or borrow-in (sub)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- result  out  WIDTH  a ± b ± cin, modulo 2^WIDTH
- cout  out  1  carry-out (add) or borrow-out (sub)
- ovf  out  1  two's-complement signed overflow

## Operation
- STAGES register stages, v[k] = valid bit of stage k; stage STAGES−1 drives the outputs.
- Stage k adds limb k (bits k·LIMB+LIMB−1 : k·LIMB) using the carry registered by stage k−1; stage 0 uses cin (add) or ~cin (sub, internal carry = ~borrow).
- Subtract is computed as a + ~b + ~bin. The registered internal carry is inverted for borrow: cout = ~carry when sub = 1.
- Each stage carries forward unprocessed upper operand limbs, sub, the running carry, and already-resolved lower result limbs (skewed pipeline). Only the limb being resolved passes through adder logic.
- ovf is computed in the last stage: add = (a_msb == b_msb) && (r_msb != a_msb); sub = (a_msb != b_msb) && (r_msb != a_msb).
- Handshake per stage: adv[STAGES−1] = out_ready | ~v[STAGES−1]; adv[k] = adv[k+1] | ~v[k]; in_ready = adv[0].
- Stage k loads when adv[k] is high: v[k] ← (k == 0 ? in_valid : v[k−1]). Data loads only when the incoming valid is high; a bubble loads v = 0 and data holds.
- Transfer occurs when in_valid & in_ready (input) or out_valid & out_ready (output). Results leave strictly in input order.
- A stage with adv low holds all contents unchanged.
- out_valid = v[STAGES−1]. result/cout/ovf are stable while out_valid & ~out_ready.

## Timing
- Reset (rst_n low, asynchronous): all v[k] = 0, every data/carry register = 0. Outputs: out_valid = 0, result = 0, cout = 0, ovf = 0. in_ready = 1, since it is combinational from the valids.
- Reset asserted mid-operation discards all in-flight operations; no partial result is ever presented.
- Latency: an operation accepted at edge n is presented with out_valid = 1 after edge n+STAGES−1, i.e. on the STAGES-th edge counting the accept edge as 1. WIDTH=64, LIMB=32: 2 cycles.
- Throughput is 1 op/cycle when out_ready is held high.
- in_ready depends combinationally on out_ready (ripple through adv chain). No combinational path exists from in_valid to out_valid.
- Full pipeline (all v = 1) with out_ready = 0: in_ready = 0 and all stages freeze.
- Simultaneous accept and emit on a full pipeline is allowed: occupancy stays STAGES.
- Critical path per stage is one LIMB-bit ripple plus mux.

## Test plan
- Add carry across all limbs: a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, sub = 0, cin = 0 → result 0, cout = 1, ovf = 0, out_valid exactly 2 cycles after accept.
- Borrow across limb boundary: sub = 1, a = 0x0000_0001_0000_0000, b = 1, cin = 0 → result 0x0000_0000_FFFF_FFFF, cout = 0, ovf = 0. Then a = 0, b = 1 → result 0xFFFF_FFFF_FFFF_FFFF, cout = 1.
- Signed overflow: sub = 1, a = 0x8000_0000_0000_0000, b = 1 → result 0x7FFF_FFFF_FFFF_FFFF, ovf = 1, cout = 0. Add 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, ovf = 1. With cin = 1 on sub, a = 5, b = 2 → 2.
- Streaming and backpressure: issue 5 back-to-back ops with out_ready = 1 → 5 results on consecutive cycles, in order. Then drop out_ready for 4 cycles while in_valid = 1 → in_ready falls once both stages are full, outputs stay stable, nothing is lost or duplicated after out_ready returns.
- Reset mid-flight: 2 ops in pipeline, pulse rst_n low asynchronously between edges → out_valid, result, cout, ovf drop to 0 immediately. in_ready = 1, and the next op completes with correct latency.
- Parametric: WIDTH = 16, LIMB = 4 (4 stages) and WIDTH = LIMB = 8 (1 stage) with 10k random ops, random sub/cin/in_valid/out_ready → matches a behavioural a ± b ± cin model bit-exact for result, cout and ovf. Latency equals STAGES.
